// File: rtl/linkspeed_tx_multi.sv
// Transmit-side LINKSPEED sequencer: sideband handshake around one point test, with
// per-group pass evaluation, bounded point-test retry on framing error and handshake timeout.
module linkspeed_tx_multi #(
  parameter int NUM_LANES      = 16,
  parameter int NUM_GROUPS     = 2,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int MAX_RETRY      = 2,
  parameter int CNT_W          = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_en,
  input  logic [3:0]                     i_sb_msg,
  input  logic                           i_sb_valid,
  input  logic                           i_point_test_ack,
  input  logic                           i_valid_framing_error,
  input  logic [NUM_LANES-1:0]           i_lanes_result,
  input  logic                           i_coming_from_repair,
  input  logic [NUM_GROUPS-1:0]          i_tx_group_functional,
  output logic [3:0]                     o_sb_msg,
  output logic                           o_sb_valid,
  output logic                           o_point_test_en,
  output logic                           o_test_ack,
  output logic                           o_timeout,
  output logic [NUM_GROUPS-1:0]          o_group_functional,
  output logic [1:0]                     o_phyretrain_error_encoding,
  output logic [2:0]                     o_exit_code,
  output logic [$clog2(MAX_RETRY+1)-1:0] o_retry_count
);

  localparam int GW = NUM_LANES / NUM_GROUPS;
  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0]    RETRY_MAX = RW'(MAX_RETRY);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [3:0] MSG_START_REQ   = 4'b0001;
  localparam logic [3:0] MSG_START_RESP  = 4'b0010;
  localparam logic [3:0] MSG_ERROR_REQ   = 4'b0011;
  localparam logic [3:0] MSG_ERROR_RESP  = 4'b0100;
  localparam logic [3:0] MSG_REPAIR_REQ  = 4'b0101;
  localparam logic [3:0] MSG_REPAIR_RESP = 4'b0110;
  localparam logic [3:0] MSG_DEGR_REQ    = 4'b0111;
  localparam logic [3:0] MSG_DEGR_RESP   = 4'b1000;
  localparam logic [3:0] MSG_DONE_REQ    = 4'b1001;
  localparam logic [3:0] MSG_DONE_RESP   = 4'b1010;
  localparam logic [3:0] MSG_PHYRT_REQ   = 4'b1011;
  localparam logic [3:0] MSG_PHYRT_RESP  = 4'b1100;

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_START      = 4'd1,
    S_PTEST      = 4'd2,
    S_ANALYZE    = 4'd3,
    S_DONE       = 4'd4,
    S_PHYRETRAIN = 4'd5,
    S_ERROR      = 4'd6,
    S_REPAIR     = 4'd7,
    S_DEGRADE    = 4'd8,
    S_FIN        = 4'd9
  } state_t;

  // Response code that completes the handshake of each waiting state.
  function automatic logic [3:0] f_resp(input state_t s);
    case (s)
      S_START:      f_resp = MSG_START_RESP;
      S_DONE:       f_resp = MSG_DONE_RESP;
      S_PHYRETRAIN: f_resp = MSG_PHYRT_RESP;
      S_ERROR:      f_resp = MSG_ERROR_RESP;
      S_REPAIR:     f_resp = MSG_REPAIR_RESP;
      S_DEGRADE:    f_resp = MSG_DEGR_RESP;
      default:      f_resp = 4'b0000;
    endcase
  endfunction

  function automatic logic f_is_hs(input state_t s);
    case (s)
      S_START, S_DONE, S_PHYRETRAIN, S_ERROR, S_REPAIR, S_DEGRADE: f_is_hs = 1'b1;
      default: f_is_hs = 1'b0;
    endcase
  endfunction

  state_t                r_state, w_state_nxt;
  logic [3:0]            r_sb_msg, w_sb_msg_nxt;
  logic                  r_sb_valid, w_sb_valid_nxt;
  logic                  r_pt_en, w_pt_en_nxt;
  logic                  r_test_ack, w_test_ack_nxt;
  logic                  r_timeout, w_timeout_nxt;
  logic [NUM_GROUPS-1:0] r_grp, w_grp_nxt;
  logic [1:0]            r_enc, w_enc_nxt;
  logic [2:0]            r_exit, w_exit_nxt;
  logic [RW-1:0]         r_retry, w_retry_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
  logic [NUM_LANES-1:0]  r_lanes, w_lanes_nxt;
  logic                  r_fe, w_fe_nxt;
  logic [NUM_GROUPS-1:0] w_gpass;
  logic                  w_match, w_partner, w_expired;

  // Per-group pass from the lane result captured at point-test ack.
  always_comb begin
    w_gpass = '0;
    for (int g = 0; g < NUM_GROUPS; g++) begin
      w_gpass[g] = &r_lanes[g*GW +: GW];
    end
  end

  assign w_match   = i_sb_valid && (i_sb_msg == f_resp(r_state));
  assign w_partner = i_sb_valid && (i_sb_msg == MSG_PHYRT_REQ);
  assign w_expired = (r_cnt == CNT_LAST);

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt    = r_state;
    w_sb_msg_nxt   = r_sb_msg;
    w_sb_valid_nxt = 1'b0;
    w_pt_en_nxt    = r_pt_en;
    w_test_ack_nxt = r_test_ack;
    w_timeout_nxt  = r_timeout;
    w_grp_nxt      = r_grp;
    w_enc_nxt      = r_enc;
    w_exit_nxt     = r_exit;
    w_retry_nxt    = r_retry;
    w_lanes_nxt    = r_lanes;
    w_fe_nxt       = r_fe;
    if (!i_en) begin
      // group mask and encoding survive a disable so the controller can still read them
      w_state_nxt    = S_IDLE;
      w_sb_msg_nxt   = 4'b0000;
      w_pt_en_nxt    = 1'b0;
      w_test_ack_nxt = 1'b0;
      w_timeout_nxt  = 1'b0;
      w_exit_nxt     = 3'd0;
      w_retry_nxt    = '0;
      w_lanes_nxt    = '0;
      w_fe_nxt       = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt    = S_START;
          w_sb_msg_nxt   = MSG_START_REQ;
          w_sb_valid_nxt = 1'b1;
          w_retry_nxt    = '0;
        end
        S_PTEST: begin
          if (i_point_test_ack) begin
            w_state_nxt = S_ANALYZE;
            w_pt_en_nxt = 1'b0;
            w_lanes_nxt = i_lanes_result;
            w_fe_nxt    = i_valid_framing_error;
          end else begin
            w_state_nxt = r_state;
          end
        end
        S_ANALYZE: begin
          w_grp_nxt = w_gpass;
          if (&w_gpass) begin
            w_enc_nxt = 2'b01;
          end else if (|w_gpass) begin
            w_enc_nxt = 2'b10;
          end else begin
            w_enc_nxt = 2'b11;
          end
          w_sb_valid_nxt = 1'b1;
          if (r_fe && (r_retry < RETRY_MAX)) begin
            w_state_nxt    = S_PTEST;
            w_pt_en_nxt    = 1'b1;
            w_retry_nxt    = r_retry + RW'(1);
            w_sb_valid_nxt = 1'b0;
          end else if (r_fe) begin
            w_state_nxt  = S_PHYRETRAIN;
            w_sb_msg_nxt = MSG_PHYRT_REQ;
          end else if (i_coming_from_repair && |(w_gpass & i_tx_group_functional)) begin
            w_state_nxt  = S_DONE;
            w_sb_msg_nxt = MSG_DONE_REQ;
          end else if (&w_gpass) begin
            w_state_nxt  = S_DONE;
            w_sb_msg_nxt = MSG_DONE_REQ;
          end else begin
            w_state_nxt  = S_ERROR;
            w_sb_msg_nxt = MSG_ERROR_REQ;
          end
        end
        S_START, S_DONE, S_PHYRETRAIN, S_ERROR, S_REPAIR, S_DEGRADE: begin
          // a matching response beats both the partner request and the timeout
          if (w_match) begin
            case (r_state)
              S_START: begin
                w_state_nxt = S_PTEST;
                w_pt_en_nxt = 1'b1;
              end
              S_ERROR: begin
                w_sb_valid_nxt = 1'b1;
                if (|r_grp) begin
                  w_state_nxt  = S_REPAIR;
                  w_sb_msg_nxt = MSG_REPAIR_REQ;
                end else begin
                  w_state_nxt  = S_DEGRADE;
                  w_sb_msg_nxt = MSG_DEGR_REQ;
                end
              end
              S_DONE: begin
                w_state_nxt = S_FIN; w_test_ack_nxt = 1'b1; w_exit_nxt = 3'd1;
              end
              S_REPAIR: begin
                w_state_nxt = S_FIN; w_test_ack_nxt = 1'b1; w_exit_nxt = 3'd2;
              end
              S_DEGRADE: begin
                w_state_nxt = S_FIN; w_test_ack_nxt = 1'b1; w_exit_nxt = 3'd3;
              end
              S_PHYRETRAIN: begin
                w_state_nxt = S_FIN; w_test_ack_nxt = 1'b1; w_exit_nxt = 3'd4;
              end
              default: w_state_nxt = r_state;
            endcase
          end else if (w_partner) begin
            w_state_nxt    = S_FIN;
            w_test_ack_nxt = 1'b1;
            w_exit_nxt     = 3'd4;
          end else if (w_expired) begin
            w_state_nxt    = S_FIN;
            w_test_ack_nxt = 1'b1;
            w_timeout_nxt  = 1'b1;
            w_exit_nxt     = 3'd5;
          end else begin
            w_state_nxt = r_state;
          end
        end
        S_FIN:   w_state_nxt = r_state;
        default: w_state_nxt = S_IDLE;
      endcase
    end
    if (w_state_nxt != r_state) begin
      w_cnt_nxt = '0;
    end else if (f_is_hs(r_state)) begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end else begin
      w_cnt_nxt = r_cnt;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_sb_msg   <= 4'b0000;
      r_sb_valid <= 1'b0;
      r_pt_en    <= 1'b0;
      r_test_ack <= 1'b0;
      r_timeout  <= 1'b0;
      r_grp      <= '0;
      r_enc      <= 2'b00;
      r_exit     <= 3'd0;
      r_retry    <= '0;
      r_cnt      <= '0;
      r_lanes    <= '0;
      r_fe       <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_sb_msg   <= w_sb_msg_nxt;
      r_sb_valid <= w_sb_valid_nxt;
      r_pt_en    <= w_pt_en_nxt;
      r_test_ack <= w_test_ack_nxt;
      r_timeout  <= w_timeout_nxt;
      r_grp      <= w_grp_nxt;
      r_enc      <= w_enc_nxt;
      r_exit     <= w_exit_nxt;
      r_retry    <= w_retry_nxt;
      r_cnt      <= w_cnt_nxt;
      r_lanes    <= w_lanes_nxt;
      r_fe       <= w_fe_nxt;
    end
  end

  assign o_sb_msg                    = r_sb_msg;
  assign o_sb_valid                  = r_sb_valid;
  assign o_point_test_en             = r_pt_en;
  assign o_test_ack                  = r_test_ack;
  assign o_timeout                   = r_timeout;
  assign o_group_functional          = r_grp;
  assign o_phyretrain_error_encoding = r_enc;
  assign o_exit_code                 = r_exit;
  assign o_retry_count               = r_retry;

endmodule

// File: tb/tb_linkspeed_tx_multi.sv
// Self-checking bench for linkspeed_tx_multi: table of analysis outcomes plus hand-written
// retry, timeout, partner-phyretrain and reset sequences; sent messages checked via a queue.
module tb_linkspeed_tx_multi;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_en;
  logic [3:0]  i_sb_msg;
  logic        i_sb_valid;
  logic        i_point_test_ack;
  logic        i_valid_framing_error;
  logic [15:0] i_lanes_result;
  logic        i_coming_from_repair;
  logic [1:0]  i_tx_group_functional;
  logic [3:0]  o_sb_msg;
  logic        o_sb_valid;
  logic        o_point_test_en;
  logic        o_test_ack;
  logic        o_timeout;
  logic [1:0]  o_group_functional;
  logic [1:0]  o_phyretrain_error_encoding;
  logic [2:0]  o_exit_code;
  logic [1:0]  o_retry_count;

  int n_vec = 0;
  int n_err = 0;
  logic [3:0] exp_q[$];

  typedef struct {
    logic [15:0] lanes;
    logic        rep;
    logic [1:0]  txgf;
    logic [3:0]  req;
    logic [1:0]  grp;
    logic [1:0]  enc;
    logic [3:0]  resp1;
    logic        two;
    logic [3:0]  req2;
    logic [3:0]  resp2;
    logic [2:0]  exit_code;
  } vec_t;

  vec_t vecs[6];

  linkspeed_tx_multi #(
    .NUM_LANES(16), .NUM_GROUPS(2), .TIMEOUT_CYCLES(8), .MAX_RETRY(2), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .i_en(i_en), .i_sb_msg(i_sb_msg), .i_sb_valid(i_sb_valid),
    .i_point_test_ack(i_point_test_ack), .i_valid_framing_error(i_valid_framing_error),
    .i_lanes_result(i_lanes_result), .i_coming_from_repair(i_coming_from_repair),
    .i_tx_group_functional(i_tx_group_functional), .o_sb_msg(o_sb_msg), .o_sb_valid(o_sb_valid),
    .o_point_test_en(o_point_test_en), .o_test_ack(o_test_ack), .o_timeout(o_timeout),
    .o_group_functional(o_group_functional),
    .o_phyretrain_error_encoding(o_phyretrain_error_encoding),
    .o_exit_code(o_exit_code), .o_retry_count(o_retry_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_resp(input logic [3:0] m);
    i_sb_msg   = m;
    i_sb_valid = 1'b1;
    tick();
    i_sb_valid = 1'b0;
    i_sb_msg   = 4'b0000;
  endtask

  task automatic start_to_ptest();
    i_en = 1'b0;
    tick();
    i_en = 1'b1;
    exp_q.push_back(4'b0001);
    tick();
    sb_resp(4'b0010);
    chk("pt_en_on", {31'd0, o_point_test_en}, 32'd1);
  endtask

  task automatic point_ack(input logic [15:0] lanes, input logic fe);
    i_lanes_result        = lanes;
    i_valid_framing_error = fe;
    i_point_test_ack      = 1'b1;
    tick();
    i_point_test_ack      = 1'b0;
    i_valid_framing_error = 1'b0;
  endtask

  // Every sideband send must match the oldest expected message.
  always @(negedge clk) begin
    if (o_sb_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_unexpected: got %0h, expected no send", o_sb_msg);
      end else begin
        chk("sb_msg", {28'd0, o_sb_msg}, {28'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{16'hFFFF, 1'b0, 2'b00, 4'b1001, 2'b11, 2'b01, 4'b1010, 1'b0, 4'b0000, 4'b0000, 3'd1};
    vecs[1] = '{16'h00FF, 1'b0, 2'b00, 4'b0011, 2'b01, 2'b10, 4'b0100, 1'b1, 4'b0101, 4'b0110, 3'd2};
    vecs[2] = '{16'h0000, 1'b0, 2'b00, 4'b0011, 2'b00, 2'b11, 4'b0100, 1'b1, 4'b0111, 4'b1000, 3'd3};
    vecs[3] = '{16'hFF00, 1'b1, 2'b10, 4'b1001, 2'b10, 2'b10, 4'b1010, 1'b0, 4'b0000, 4'b0000, 3'd1};
    vecs[4] = '{16'hFF00, 1'b1, 2'b01, 4'b0011, 2'b10, 2'b10, 4'b0100, 1'b1, 4'b0101, 4'b0110, 3'd2};
    vecs[5] = '{16'h7FFF, 1'b1, 2'b11, 4'b1001, 2'b01, 2'b10, 4'b1010, 1'b0, 4'b0000, 4'b0000, 3'd1};

    rst = 1'b1; i_en = 1'b0; i_sb_msg = 4'b0000; i_sb_valid = 1'b0;
    i_point_test_ack = 1'b0; i_valid_framing_error = 1'b0; i_lanes_result = 16'h0000;
    i_coming_from_repair = 1'b0; i_tx_group_functional = 2'b00;
    tick(); tick();
    rst = 1'b0;
    chk("rst_outputs", {o_sb_msg, o_sb_valid, o_point_test_en, o_test_ack, o_timeout,
        o_group_functional, o_phyretrain_error_encoding, o_exit_code, o_retry_count},
        32'd0);

    for (int i = 0; i < 6; i++) begin
      i_coming_from_repair  = vecs[i].rep;
      i_tx_group_functional = vecs[i].txgf;
      start_to_ptest();
      point_ack(vecs[i].lanes, 1'b0);
      chk("pt_en_off", {31'd0, o_point_test_en}, 32'd0);
      exp_q.push_back(vecs[i].req);
      tick();
      chk("group_functional", {30'd0, o_group_functional}, {30'd0, vecs[i].grp});
      chk("encoding", {30'd0, o_phyretrain_error_encoding}, {30'd0, vecs[i].enc});
      if (vecs[i].two) exp_q.push_back(vecs[i].req2);
      sb_resp(vecs[i].resp1);
      if (vecs[i].two) sb_resp(vecs[i].resp2);
      chk("test_ack", {31'd0, o_test_ack}, 32'd1);
      chk("exit_code", {29'd0, o_exit_code}, {29'd0, vecs[i].exit_code});
      chk("no_timeout", {31'd0, o_timeout}, 32'd0);
    end
    i_coming_from_repair  = 1'b0;
    i_tx_group_functional = 2'b00;

    // disable keeps the group mask and encoding from the last run
    i_en = 1'b0;
    tick();
    chk("en_low_hold", {24'd0, o_group_functional, o_phyretrain_error_encoding,
        o_test_ack, o_exit_code}, {24'd0, 2'b01, 2'b10, 1'b0, 3'd0});

    // framing error three times: two reruns, then phyretrain
    start_to_ptest();
    point_ack(16'hFFFF, 1'b1);
    tick();
    chk("retry1", {30'd0, o_retry_count}, 32'd1);
    chk("retry1_pt_en", {31'd0, o_point_test_en}, 32'd1);
    point_ack(16'hFFFF, 1'b1);
    tick();
    chk("retry2", {30'd0, o_retry_count}, 32'd2);
    point_ack(16'hFFFF, 1'b1);
    exp_q.push_back(4'b1011);
    tick();
    chk("retry_hold", {30'd0, o_retry_count}, 32'd2);
    sb_resp(4'b1100);
    chk("phyretrain_exit", {28'd0, o_test_ack, o_exit_code}, {28'd0, 1'b1, 3'd4});

    // no start response: timeout lands 8 cycles after START entry
    i_en = 1'b0;
    tick();
    i_en = 1'b1;
    exp_q.push_back(4'b0001);
    tick();
    repeat (7) tick();
    chk("before_timeout", {30'd0, o_timeout, o_test_ack}, 32'd0);
    tick();
    chk("timeout", {28'd0, o_timeout, o_exit_code}, {28'd0, 1'b1, 3'd5});

    // response in the last allowed cycle wins over the timeout
    i_en = 1'b0;
    tick();
    i_en = 1'b1;
    exp_q.push_back(4'b0001);
    tick();
    repeat (7) tick();
    sb_resp(4'b0010);
    chk("late_resp", {30'd0, o_point_test_en, o_timeout}, {30'd0, 1'b1, 1'b0});
    repeat (20) tick();
    chk("ptest_no_timeout", {30'd0, o_point_test_en, o_timeout}, {30'd0, 1'b1, 1'b0});

    // partner phyretrain request during ERROR exits without a send
    point_ack(16'h00FF, 1'b0);
    exp_q.push_back(4'b0011);
    tick();
    sb_resp(4'b1011);
    chk("partner_phyrt", {24'd0, o_sb_msg, o_exit_code, o_test_ack},
        {24'd0, 4'b0011, 3'd4, 1'b1});

    // an unexpected code in DONE does not restart the timeout
    start_to_ptest();
    point_ack(16'hFFFF, 1'b0);
    exp_q.push_back(4'b1001);
    tick();
    repeat (3) tick();
    sb_resp(4'b0110);
    repeat (3) tick();
    chk("done_pre_timeout", {31'd0, o_timeout}, 32'd0);
    tick();
    chk("done_timeout", {28'd0, o_timeout, o_exit_code}, {28'd0, 1'b1, 3'd5});

    // reset in the middle of REPAIR
    start_to_ptest();
    point_ack(16'h00FF, 1'b0);
    exp_q.push_back(4'b0011);
    tick();
    exp_q.push_back(4'b0101);
    sb_resp(4'b0100);
    chk("in_repair", {28'd0, o_sb_msg}, {28'd0, 4'b0101});
    rst = 1'b1;
    tick();
    chk("rst_mid_repair", {o_sb_msg, o_sb_valid, o_point_test_en, o_test_ack, o_timeout,
        o_group_functional, o_phyretrain_error_encoding, o_exit_code, o_retry_count},
        32'd0);
    i_en = 1'b0;
    rst  = 1'b0;
    repeat (3) tick();

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
